// File: rtl/de1_soc_button_pio_if.sv
// -----------------------------------------------------------------------------
// de1_soc_button_pio_if
// Register bus between a host and the button PIO block.
//
// Signals:
//   address     register select (0 DATA, 1 EDGE_SEL, 2 IRQ_MASK, 3 EDGE_CAPTURE)
//   chipselect  slave select
//   write_n     active-low write strobe, only meaningful with chipselect high
//   writedata   write data
//   readdata    registered read data, valid one cycle after the address
//   irq         level interrupt request from the PIO
//
// Modports:
//   master  drives address/chipselect/write_n/writedata, receives readdata/irq
//   slave   the PIO side
// -----------------------------------------------------------------------------
interface de1_soc_button_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/de1_soc_button_pio.sv
// -----------------------------------------------------------------------------
// de1_soc_button_pio
// Push-button parallel input port: synchronises and debounces WIDTH raw
// button pins, captures selected rising/falling edges of the debounced
// levels, and raises a level interrupt for captured edges that are unmasked.
//
// Parameters:
//   WIDTH            number of button channels (1..16)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change;
//                    0 removes the debounce counters entirely
//   INVERT           1 when the pins are active-low
//
// Ports:
//   clk      sole clock, rising edge
//   reset    asynchronous active-high reset
//   in_port  raw asynchronous button pins
//   bus      register bus (slave side): address, chipselect, write_n,
//            writedata in; readdata, irq out
// -----------------------------------------------------------------------------
module de1_soc_button_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit INVERT          = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in_port,
   de1_soc_button_pio_if.slave  bus
);

   logic [WIDTH-1:0] lvl;
   logic [WIDTH-1:0] syncMeta_q;
   logic [WIDTH-1:0] syncOut_q;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] riseEn_q;
   logic [WIDTH-1:0] riseEn_d;
   logic [WIDTH-1:0] fallEn_q;
   logic [WIDTH-1:0] fallEn_d;
   logic [WIDTH-1:0] irqMask_q;
   logic [WIDTH-1:0] irqMask_d;
   logic [WIDTH-1:0] edgeCap_q;
   logic [WIDTH-1:0] edgeCap_d;
   logic [WIDTH-1:0] clearBits;
   logic [WIDTH-1:0] riseEvt;
   logic [WIDTH-1:0] fallEvt;
   logic [31:0]      readData_q;
   logic [31:0]      readData_d;
   logic             wrEn;
   logic             unusedWriteBits;

   // Normalise polarity so that a pressed button is always a 1 from here on;
   // with idle active-low pins this keeps the post-reset synchroniser state
   // equal to the idle level and so no edge appears after reset.
   assign lvl  = in_port ^ {WIDTH{INVERT}};
   assign wrEn = bus.chipselect & ~bus.write_n;

   // Only the low WIDTH bits and the fall-enable field of writedata matter.
   assign unusedWriteBits = ^bus.writedata;

   // Two-flop synchroniser for the asynchronous pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncMeta_q <= '0;
         syncOut_q  <= '0;
      end else begin
         syncMeta_q <= lvl;
         syncOut_q  <= syncMeta_q;
      end
   end

   // Debounce. Each channel counts consecutive cycles in which the
   // synchronised level disagrees with the accepted level; any agreement
   // restarts the count, so short glitches never reach db. On the final
   // count the new level is accepted and the counter returns to zero, which
   // means it can never wrap. With no debounce the accepted level is just
   // the synchronised level one cycle later.
   generate
      if (DEBOUNCE_CYCLES == 0) begin : gNoDebounce
         always_comb begin
            db_d = syncOut_q;
         end
      end else begin : gDebounce
         localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

         logic [CntW-1:0] cnt_q [WIDTH];
         logic [CntW-1:0] cnt_d [WIDTH];

         always_comb begin
            db_d = db_q;
            for (int i = 0; i < WIDTH; i++) begin
               cnt_d[i] = '0;
               if (syncOut_q[i] != db_q[i]) begin
                  if (cnt_q[i] == CntLast) begin
                     db_d[i] = syncOut_q[i];
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end
         end

         // Counters reset with everything else, so a reset in the middle of
         // a debounce window discards the partial count.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= cnt_d[i];
               end
            end
         end
      end
   endgenerate

   // Register writes and edge capture. Edges are detected on the accepted
   // level as it changes, so capture lands on the same edge as the db update.
   // The capture register is write-1-to-clear, and a new edge on a bit being
   // cleared in the same cycle wins so no event is ever lost.
   always_comb begin
      riseEn_d  = riseEn_q;
      fallEn_d  = fallEn_q;
      irqMask_d = irqMask_q;
      clearBits = '0;
      if (wrEn) begin
         case (bus.address)
            2'd1: begin
               riseEn_d = bus.writedata[WIDTH-1:0];
               fallEn_d = bus.writedata[16 +: WIDTH];
            end
            2'd2: irqMask_d = bus.writedata[WIDTH-1:0];
            2'd3: clearBits = bus.writedata[WIDTH-1:0];
            default: ;
         endcase
      end
      riseEvt   = ~db_q & db_d & riseEn_q;
      fallEvt   = db_q & ~db_d & fallEn_q;
      edgeCap_d = (edgeCap_q & ~clearBits) | riseEvt | fallEvt;
   end

   // Read mux from the current register contents, so a read returns the
   // state from before any write happening in the same cycle.
   always_comb begin
      readData_d = '0;
      case (bus.address)
         2'd0: readData_d[WIDTH-1:0] = db_q;
         2'd1: begin
            readData_d[WIDTH-1:0]  = riseEn_q;
            readData_d[16 +: WIDTH] = fallEn_q;
         end
         2'd2: readData_d[WIDTH-1:0] = irqMask_q;
         2'd3: readData_d[WIDTH-1:0] = edgeCap_q;
      endcase
   end

   // State registers; readdata is refreshed every cycle for one-cycle latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q       <= '0;
         riseEn_q   <= '0;
         fallEn_q   <= '0;
         irqMask_q  <= '0;
         edgeCap_q  <= '0;
         readData_q <= '0;
      end else begin
         db_q       <= db_d;
         riseEn_q   <= riseEn_d;
         fallEn_q   <= fallEn_d;
         irqMask_q  <= irqMask_d;
         edgeCap_q  <= edgeCap_d;
         readData_q <= readData_d;
      end
   end

   assign bus.readdata = readData_q;
   assign bus.irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_de1_soc_button_pio.sv
// -----------------------------------------------------------------------------
// tb_de1_soc_button_pio
// Testbench for de1_soc_button_pio with WIDTH=4, DEBOUNCE_CYCLES=4, INVERT=1.
// A reference model sampled on every rising edge pushes the expected irq and
// (for reads) readdata into a queue; a monitor on the falling edge pops and
// compares. Directed scenarios also compare a few values against constants.
// -----------------------------------------------------------------------------
module tb_de1_soc_button_pio;

   localparam int W = 4;
   localparam int D = 4;

   typedef struct {
      bit          isRead;
      logic [31:0] data;
      logic        irq;
   } rec_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] pins;
   int           errors;
   int           checks;
   rec_t         scoreQ[$];

   // Reference model state
   logic [W-1:0] hist[$];
   logic [W-1:0] mDb;
   logic [W-1:0] mRise;
   logic [W-1:0] mFall;
   logic [W-1:0] mMask;
   logic [W-1:0] mCap;

   de1_soc_button_pio_if bus ();

   de1_soc_button_pio #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .INVERT          (1'b1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_port (pins),
      .bus     (bus.slave)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a channel accepts a new level once the pressed/released
   // level seen at the pins has been constant for D consecutive samples,
   // observed two cycles late through the synchroniser.
   always @(posedge clk) begin
      rec_t         r;
      logic [W-1:0] lvl;
      logic [W-1:0] newDb;
      logic [W-1:0] clr;
      logic         wr;
      logic         stable;
      int           last;
      r.isRead = 1'b0;
      r.data   = '0;
      r.irq    = 1'b0;
      if (reset) begin
         mDb   = '0;
         mRise = '0;
         mFall = '0;
         mMask = '0;
         mCap  = '0;
         hist.push_back('0);
         r.isRead = 1'b1;
      end else begin
         lvl = ~pins;
         wr  = bus.chipselect && !bus.write_n;
         r.isRead = bus.chipselect && bus.write_n;
         case (bus.address)
            2'd0: r.data = {28'd0, mDb};
            2'd1: r.data = {12'd0, mFall, 12'd0, mRise};
            2'd2: r.data = {28'd0, mMask};
            default: r.data = {28'd0, mCap};
         endcase
         last  = hist.size() - 1;
         newDb = mDb;
         for (int ch = 0; ch < W; ch++) begin
            stable = 1'b1;
            for (int k = 1; k <= D; k++) begin
               if (hist[last - k][ch] !== ~mDb[ch]) stable = 1'b0;
            end
            if (stable) newDb[ch] = ~mDb[ch];
         end
         clr = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
         mCap = (mCap & ~clr) | (~mDb & newDb & mRise) | (mDb & ~newDb & mFall);
         if (wr && bus.address == 2'd1) begin
            mRise = bus.writedata[W-1:0];
            mFall = bus.writedata[16 +: W];
         end
         if (wr && bus.address == 2'd2) mMask = bus.writedata[W-1:0];
         mDb = newDb;
         hist.push_back(lvl);
      end
      r.irq = |(mCap & mMask);
      scoreQ.push_back(r);
   end

   // Monitor: one record per clock, compared after the edge has settled.
   always @(negedge clk) begin
      rec_t r;
      if ($time > 0) begin
         if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: no expected record at %0t", $time);
         end else begin
            r = scoreQ.pop_front();
            checks++;
            if (bus.irq !== r.irq) begin
               errors++;
               $display("[TB] FAIL monitor irq at %0t: got %b expected %b", $time, bus.irq, r.irq);
            end
            if (r.isRead) begin
               checks++;
               if (bus.readdata !== r.data) begin
                  errors++;
                  $display("[TB] FAIL monitor readdata at %0t: got 0x%08h expected 0x%08h",
                           $time, bus.readdata, r.data);
               end
            end
         end
      end
   end

   // Compare an observed value against a fixed expectation.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // One bus cycle, entered and left on a falling edge; after a read the
   // registered readdata is already visible on return.
   task automatic applyStimulus(input bit isWrite, input logic [1:0] addr, input logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.write_n    = !isWrite;
      bus.address    = addr;
      bus.writedata  = data;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 8; i++) hist.push_back('0);
      reset          = 1'b1;
      pins           = '1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 2'd0;
      bus.writedata  = '0;
      idle(4);
      #1 reset = 1'b0;
      idle(2);

      // Reset state
      applyStimulus(1'b0, 2'd0, 32'd0);
      checkOutput("reset DATA", bus.readdata, 32'h0);
      checkOutput("reset irq", {31'd0, bus.irq}, 32'h0);

      // Press ch0 with rise enabled and unmasked; watch the exact latency
      applyStimulus(1'b1, 2'd1, 32'h0000_0001);
      applyStimulus(1'b1, 2'd2, 32'h0000_0001);
      pins[0] = 1'b0;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = 2'd0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 5) checkOutput("ch0 irq before commit", {31'd0, bus.irq}, 32'h0);
         if (k == 6) begin
            checkOutput("ch0 irq at commit", {31'd0, bus.irq}, 32'h1);
            checkOutput("ch0 DATA before commit", bus.readdata, 32'h0);
         end
         if (k == 7) checkOutput("ch0 DATA after commit", bus.readdata, 32'h1);
      end
      bus.chipselect = 1'b0;
      applyStimulus(1'b0, 2'd3, 32'd0);
      checkOutput("ch0 capture", bus.readdata, 32'h1);

      // Short glitch on ch1 must be filtered
      applyStimulus(1'b1, 2'd1, 32'h0001_0003);
      pins[1] = 1'b0;
      idle(3);
      pins[1] = 1'b1;
      idle(8);
      applyStimulus(1'b0, 2'd0, 32'd0);
      checkOutput("glitch DATA", bus.readdata, 32'h1);
      applyStimulus(1'b0, 2'd3, 32'd0);
      checkOutput("glitch capture", bus.readdata, 32'h1);

      // Clear and new fall on ch0 in the same cycle: set wins
      pins[0] = 1'b1;
      idle(5);
      applyStimulus(1'b1, 2'd3, 32'h0000_0001);
      applyStimulus(1'b0, 2'd3, 32'd0);
      checkOutput("set beats clear", bus.readdata, 32'h1);
      checkOutput("irq after set beats clear", {31'd0, bus.irq}, 32'h1);
      applyStimulus(1'b1, 2'd3, 32'h0000_0001);
      applyStimulus(1'b0, 2'd3, 32'd0);
      checkOutput("capture cleared", bus.readdata, 32'h0);

      // Masked capture on ch2, then unmask and clear
      applyStimulus(1'b1, 2'd2, 32'h0000_0000);
      applyStimulus(1'b1, 2'd1, 32'h0000_0004);
      pins[2] = 1'b0;
      idle(8);
      checkOutput("masked irq", {31'd0, bus.irq}, 32'h0);
      applyStimulus(1'b0, 2'd3, 32'd0);
      checkOutput("ch2 capture", bus.readdata, 32'h4);
      applyStimulus(1'b1, 2'd2, 32'h0000_0004);
      checkOutput("unmasked irq", {31'd0, bus.irq}, 32'h1);
      applyStimulus(1'b1, 2'd3, 32'h0000_0004);
      checkOutput("irq after clear", {31'd0, bus.irq}, 32'h0);
      pins[2] = 1'b1;
      idle(8);

      // Reset in the middle of a ch3 debounce
      pins[3] = 1'b0;
      idle(4);
      #1 reset = 1'b1;
      idle(3);
      #1 reset = 1'b0;
      checkOutput("DATA after mid reset", bus.readdata, 32'h0);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = 2'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 6) checkOutput("ch3 DATA not yet", bus.readdata, 32'h0);
         if (k == 7) checkOutput("ch3 DATA fresh latency", bus.readdata, 32'h8);
      end
      bus.chipselect = 1'b0;
      pins[3] = 1'b1;
      idle(8);

      // Randomised pins and bus traffic against the model
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int op;
         for (int ch = 0; ch < W; ch++) begin
            if ($urandom_range(0, 5) == 0) pins[ch] = ~pins[ch];
         end
         op = $urandom_range(0, 9);
         bus.address   = 2'($urandom_range(0, 3));
         bus.writedata = $urandom;
         if (op < 4) begin
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b1;
         end else if (op < 6) begin
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b0;
         end else begin
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = 1'b1;
         end
         @(negedge clk);
      end
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      idle(2);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/de1_soc_button_pio.md
DE1_SOC_BUTTON_PIO -- requirements
Module: de1_soc_button_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of button channels, legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a level change is accepted; 0 bypasses debounce.
REQ-003 Parameter INVERT, default 1: 1 means the pins are active-low, and each channel is inverted before synchronisation.
REQ-004 Port clk, input, 1: sole clock; all state is on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port address, input, 2: register select (0 DATA, 1 EDGE_SEL, 2 IRQ_MASK, 3 EDGE_CAPTURE).
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, WIDTH: raw asynchronous button pins.
REQ-011 Port readdata, output, 32: registered read data, with unused bits 0.
REQ-012 Port irq, output, 1: level interrupt request.

Function
REQ-013 The block SHALL form lvl[i] = in_port[i] XOR INVERT and pass it through a 2-flop synchroniser, sync[i].
REQ-014 Each channel SHALL have a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1) and a debounced state db[i].
REQ-015 The block SHALL clear cnt[i] in every cycle where sync[i] == db[i].
REQ-016 In every cycle where sync[i] != db[i], cnt[i] SHALL increment; when cnt[i] == DEBOUNCE_CYCLES-1, db[i] <= sync[i] and cnt[i] <= 0 instead.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave db[i] unchanged and restart the count; the counter SHALL never wrap.
REQ-018 With DEBOUNCE_CYCLES = 0, db[i] SHALL be sync[i] registered one cycle, and the counters SHALL be removed.
REQ-019 Total latency from a clean pin change to db update SHALL be 2 + max(DEBOUNCE_CYCLES,1) cycles.
REQ-020 EDGE_SEL register: bits [WIDTH-1:0] are rise_en and bits [16+WIDTH-1:16] are fall_en; all other bits read 0.
REQ-021 A db[i] 0->1 update with rise_en[i], or a 1->0 update with fall_en[i], SHALL set edge_capture[i] in the same clock edge that updates db[i].
REQ-022 A write to address 3 SHALL clear every edge_capture[i] whose writedata[i] = 1 (write-1-to-clear).
REQ-023 If a clear and a new edge hit the same bit in the same cycle, the set SHALL win.
REQ-024 A write to address 2 SHALL load irq_mask <= writedata[WIDTH-1:0].
REQ-025 A write to address 1 SHALL load rise_en and fall_en from the corresponding writedata bits.
REQ-026 A write to address 0 SHALL be ignored.
REQ-027 A write SHALL occur when chipselect = 1 and write_n = 0; it takes effect on that clock edge.
REQ-028 irq SHALL equal |(edge_capture & irq_mask), combinational from registers only.
REQ-029 readdata SHALL be registered every cycle from the current address, giving read latency 1.
REQ-030 readdata SHALL reflect register state before any same-cycle write.
REQ-031 Readback values: address 0 reads db, address 1 reads EDGE_SEL, address 2 reads irq_mask, address 3 reads edge_capture.
REQ-032 Reads SHALL have no side effects.

Reset
REQ-033 While reset = 1, sync, db, cnt, edge_capture, irq_mask, rise_en, fall_en and readdata SHALL be 0, and irq SHALL be 0.
REQ-034 Buttons held pressed through reset SHALL be accepted as a normal rising change after release of reset; no spurious edge SHALL be generated from the synchroniser reset state when buttons are idle.
REQ-035 Reset asserted mid-debounce SHALL abort the count; no partial count SHALL survive.
REQ-036 Reset deassertion SHALL be synchronised externally; the block SHALL treat the first clk edge after deassertion as cycle 0.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, INVERT=1)
REQ-037 Scenario 1: reset, then read address 0 -> readdata = 0x0, irq = 0.
REQ-038 Scenario 2: rise_en = 0x1, mask = 0x1, then in_port[0] 1->0 held 10 cycles -> DATA = 0x1 exactly 6 cycles after the pin change, EDGE_CAPTURE = 0x1, irq = 1 in the same cycle.
REQ-039 Scenario 3: in_port[1] low for 3 cycles, then high -> DATA bit1 stays 0 and EDGE_CAPTURE bit1 stays 0.
REQ-040 Scenario 4: with capture = 0x1, write 0x1 to address 3 in the same cycle a new fall on channel 0 commits (fall_en = 0x1) -> EDGE_CAPTURE stays 0x1 and irq stays 1.
REQ-041 Scenario 5: edge captured on ch2 with mask 0x0 -> irq = 0; then write mask 0x4 -> irq = 1 next cycle; then write 0x4 to address 3 -> irq = 0.
REQ-042 Scenario 6: assert reset midway through a 4-cycle debounce on ch3 -> after reset, DATA = 0; the pin still held low -> DATA bit3 = 1 only after a fresh 6-cycle latency.
